// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Runs the inhibit / request-to-send sequence, then shifts one command byte
// (LSB first), odd parity and stop bit out on device-generated clock falls
// and checks the device ACK bit. Drives the shared pins through open-drain
// enables and flags busy while it owns the bus.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 250,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int FILT_W    = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // Odd parity over a command byte: 1 when the byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    logic              clk_meta_r;
    logic              clk_sync_r;
    logic              data_meta_r;
    logic              data_sync_r;
    logic              clk_filt_r;
    logic [FILT_W-1:0] filt_cnt_r;
    logic              clk_fall_r;
    logic              clk_rise_r;
    logic              filt_accept_s;

    state_t            state_r;
    logic [7:0]        shift_r;
    logic              parity_r;
    logic [3:0]        bit_cnt_r;
    logic [CNT_W-1:0]  cnt_r;

    // Two-flop synchronisers for both asynchronous pin levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk_in;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data_in;
            data_sync_r <= data_meta_r;
        end
    end

    // A new clock level is accepted on its FILTER_LEN-th consecutive sample.
    always_comb begin
        filt_accept_s = 1'b0;
        if ((clk_sync_r != clk_filt_r) && (filt_cnt_r == FILT_W'(FILTER_LEN - 1))) begin
            filt_accept_s = 1'b1;
        end else begin
            filt_accept_s = 1'b0;
        end
    end

    // Deglitcher for ps2_clk with registered one-cycle edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_r <= 1'b1;
            filt_cnt_r <= '0;
            clk_fall_r <= 1'b0;
            clk_rise_r <= 1'b0;
        end else begin
            clk_fall_r <= filt_accept_s & clk_filt_r;
            clk_rise_r <= filt_accept_s & ~clk_filt_r;
            if (clk_sync_r == clk_filt_r) begin
                filt_cnt_r <= '0;
            end else if (filt_accept_s) begin
                clk_filt_r <= clk_sync_r;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FILT_W'(1);
            end
        end
    end

    // Transfer sequencer: handshake, inhibit, request, bit shifting, ACK and timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            tx_ready    <= 1'b0;
            shift_r     <= 8'h00;
            parity_r    <= 1'b0;
            bit_cnt_r   <= 4'd0;
            cnt_r       <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shift_r    <= tx_data;
                        parity_r   <= odd_parity(tx_data);
                        bit_cnt_r  <= 4'd0;
                        cnt_r      <= '0;
                        busy       <= 1'b1;
                        tx_ready   <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        state_r    <= ST_INHIBIT;
                    end else begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt_r == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        cnt_r       <= '0;
                        ps2_data_oe <= 1'b1;
                        state_r     <= ST_REQ;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_REQ: begin
                    if (cnt_r == CNT_W'(REQ_CYCLES - 1)) begin
                        cnt_r      <= '0;
                        ps2_clk_oe <= 1'b0;
                        state_r    <= ST_SEND;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        tx_ready    <= 1'b1;
                        error       <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else if (clk_fall_r) begin
                        cnt_r     <= '0;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        case (bit_cnt_r)
                            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                                ps2_data_oe <= ~shift_r[0];
                                shift_r     <= {1'b0, shift_r[7:1]};
                            end
                            4'd8: begin
                                ps2_data_oe <= ~parity_r;
                            end
                            4'd9: begin
                                ps2_data_oe <= 1'b0;
                            end
                            4'd10: begin
                                if (data_sync_r) begin
                                    busy     <= 1'b0;
                                    tx_ready <= 1'b1;
                                    error    <= 1'b1;
                                    state_r  <= ST_IDLE;
                                end else begin
                                    state_r <= ST_WAIT_IDLE;
                                end
                            end
                            default: begin
                                ps2_data_oe <= 1'b0;
                                busy        <= 1'b0;
                                tx_ready    <= 1'b1;
                                error       <= 1'b1;
                                state_r     <= ST_IDLE;
                            end
                        endcase
                    end else if (clk_rise_r && (bit_cnt_r != 4'd0)) begin
                        // The rise before the first fall is only the echo of our
                        // own clock release, so it does not restart the timeout.
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        tx_ready    <= 1'b1;
                        error       <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else if (clk_filt_r && data_sync_r) begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        done     <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else if (clk_fall_r || clk_rise_r) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    tx_ready    <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a behavioural PS/2 device
// that clocks the frame and captures bits on its rising clock edges.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int REQ  = 5;
    localparam int FLT  = 2;
    localparam int TO   = 2000;
    localparam int HALF = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       dut_done;
    logic       dut_error;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic glitch   = 1'b0;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe & ~glitch;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES(REQ),
        .FILTER_LEN(FLT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(dut_done),
        .error(dut_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame as the device sees it: data LSB first, odd parity, stop.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    // Pulse counters and end-of-transfer invariants.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut_done === 1'b1) done_cnt++;
            if (dut_error === 1'b1) err_cnt++;
            if (dut_done === 1'b1 || dut_error === 1'b1) begin
                chk("end_busy_ready", {30'd0, busy, tx_ready}, 32'd1);
                chk("done_err_excl", {31'd0, dut_done & dut_error}, 32'd0);
            end
            if (dut_error === 1'b1) chk("err_oe_low", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        end
    end

    // Behavioural device: wait for request-to-send, then generate n_clk pulses.
    task automatic device_frame(input logic nack, input int n_clk, input bit glitchy,
                                output logic [9:0] cap);
        int guard = 0;
        cap = 10'd0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        chk("rts_seen", {31'd0, guard < 4000}, 32'd1);
        repeat (20) @(negedge clk);
        for (int i = 1; i <= n_clk; i++) begin
            if (i == 11) begin
                dev_data = nack;
                repeat (10) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) cap[i-1] = ps2_data_in;
            if (glitchy) begin
                repeat (40) @(negedge clk);
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
                repeat (HALF - 41) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_data = 1'b1;
    endtask

    // Handshake one byte and measure how long the clock is inhibited alone.
    task automatic accept(input logic [7:0] b);
        int n = 0;
        done_cnt = 0;
        err_cnt  = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept_state", {29'd0, busy, tx_ready, ps2_clk_oe}, 32'd5);
        while (ps2_data_oe === 1'b0 && ps2_clk_oe === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, INH);
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (done_cnt + err_cnt == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("end_in_time", {31'd0, n < bound}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic xfer_ack(input logic [7:0] b, input string tag);
        logic [9:0] cap;
        accept(b);
        device_frame(1'b0, 11, 1'b0, cap);
        wait_end(1000);
        chk({tag, "_frame"}, {22'd0, cap}, {22'd0, exp_frame(b)});
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_idle"}, {30'd0, busy, tx_ready}, 32'd1);
    endtask

    initial begin
        logic [9:0] cap1;
        logic [9:0] cap2;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {27'd0, tx_ready, ps2_clk_oe, ps2_data_oe, busy, dut_done | dut_error},
            32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", {31'd0, tx_ready}, 32'd1);

        // ACKed transfers with odd and even parity
        xfer_ack(8'hED, "ed");
        xfer_ack(8'h07, "x07");

        // NACK: device leaves data high on the 11th clock
        accept(8'hFF);
        device_frame(1'b1, 11, 1'b0, cap1);
        wait_end(1000);
        chk("nack_frame", {22'd0, cap1}, {22'd0, exp_frame(8'hFF)});
        chk("nack_err", err_cnt, 1);
        chk("nack_done", done_cnt, 0);
        chk("nack_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

        // Timeout: device never clocks after the request
        accept(8'hF3);
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (dut_error !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_len", n, TO);
        repeat (3) @(negedge clk);
        chk("timeout_err_once", err_cnt, 1);
        chk("timeout_idle", {29'd0, busy, tx_ready, ps2_clk_oe | ps2_data_oe}, 32'd2);

        // Reset in the middle of a frame, then a clean transfer
        accept(8'hED);
        device_frame(1'b0, 4, 1'b0, cap1);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", {28'd0, ps2_clk_oe, ps2_data_oe, busy, tx_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
        xfer_ack(8'hF4, "post_rst");

        // tx_valid held, data changed mid-frame, glitches on the clock line
        done_cnt = 0;
        err_cnt  = 0;
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("hold_accept", {31'd0, busy}, 32'd1);
        fork
            device_frame(1'b0, 11, 1'b1, cap1);
            begin
                int m = 0;
                repeat (1000) @(negedge clk);
                tx_data = 8'hF4;
                while (dut_done !== 1'b1 && m < 8000) begin
                    @(negedge clk);
                    m++;
                end
                chk("hold_done_seen", {31'd0, m < 8000}, 32'd1);
                @(negedge clk);
                chk("hold_reaccept", {30'd0, busy, tx_ready}, 32'd2);
                tx_valid = 1'b0;
            end
        join
        chk("hold_first_frame", {22'd0, cap1}, {22'd0, exp_frame(8'hED)});
        chk("hold_first_err", err_cnt, 0);
        done_cnt = 0;
        device_frame(1'b0, 11, 1'b0, cap2);
        wait_end(1000);
        chk("hold_second_frame", {22'd0, cap2}, {22'd0, exp_frame(8'hF4)});
        chk("hold_second_done", done_cnt, 1);

        // Random command bytes against the frame model
        for (int k = 0; k < 3; k++) begin
            xfer_ack(8'($urandom_range(0, 255)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: it serialises one command byte to the keyboard over the open-drain PS/2 clock/data pair, for example 0xED set-LEDs, 0xFF reset or 0xF3 typematic. It sits beside the existing PS/2 receive path in the top level and shares the same `ps2_clk`/`ps2_data` pins through open-drain enables. While it drives the bus it raises `busy` so the receive path ignores the line. It runs the full request-to-send sequence, clocks out data, parity and stop bits on device-generated clock edges, and checks the device ACK bit.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 5000: clk cycles that ps2_clk is held low before the request (100 µs at 50 MHz).
- `REQ_CYCLES`, default 250: clk cycles that clock and data are both held low before the clock is released (5 µs).
- `FILTER_LEN`, default 8: consecutive identical synchronised samples needed to accept a new ps2_clk level.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum clk cycles between accepted ps2_clk edges (20 ms).

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `tx_data`, in, 8: command byte; sampled on handshake.
- `tx_valid`, in, 1: request to send `tx_data`.
- `tx_ready`, out, 1: high only in IDLE; a transfer is accepted when `tx_valid & tx_ready` at a clk rising edge.
- `ps2_clk_in`, in, 1: raw pin level of ps2_clk (asynchronous).
- `ps2_data_in`, in, 1: raw pin level of ps2_data (asynchronous).
- `ps2_clk_oe`, out, 1: 1 pulls ps2_clk low; 0 releases it.
- `ps2_data_oe`, out, 1: 1 pulls ps2_data low; 0 releases it.
- `busy`, out, 1: high from the accept cycle until the block returns to IDLE.
- `done`, out, 1: one-cycle pulse when the byte was ACKed and the bus returned to idle.
- `error`, out, 1: one-cycle pulse on NACK or timeout.

## Operation
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - ps2_clk then passes a FILTER_LEN deglitcher.
  - A falling edge is a filtered 1→0 transition; a rising edge is 0→1.
- On accept:
  - Latch tx_data into the shift register.
  - Compute the odd parity bit = ~^tx_data.
  - Clear the bit counter.
- State machine:
  - IDLE: both oe = 0; tx_ready = 1. Go to INHIBIT on accept.
  - INHIBIT: clk_oe = 1, data_oe = 0, held for INHIBIT_CYCLES. Then go to REQ.
  - REQ: clk_oe = 1, data_oe = 1 (start bit), held for REQ_CYCLES. Then go to SEND.
  - SEND: clk_oe = 0. Frame bits are driven on each falling edge:
    - Falling edges 1–8: drive data bits 0–7, LSB first. data_oe = ~bit.
    - Falling edge 9: drive parity.
    - Falling edge 10: drive stop, data_oe = 0.
    - Falling edge 11: sample synchronised ps2_data. 0 = ACK, go to WAIT_IDLE. 1 = NACK, pulse error and go to IDLE.
  - WAIT_IDLE: wait until the filtered clock and synchronised data are both high. Then pulse done and go to IDLE.
- Timeout:
  - In SEND and WAIT_IDLE, a counter clears on every accepted edge (either polarity).
  - When the counter reaches TIMEOUT_CYCLES: both oe = 0, pulse error, go to IDLE.
- Reset: synchronous rst in any state (mid-frame included):
  - Next cycle: state = IDLE, both oe = 0, busy = 0, done = 0, error = 0.
  - tx_ready = 0 while rst is high, 1 from the first cycle after release.
  - A partially sent byte is discarded.
- tx_valid outside IDLE is ignored and not queued. done and error are never both high in the same cycle.

## Timing
- All outputs are registered.
- Accept at edge T:
  - busy = 1, tx_ready = 0 and clk_oe = 1 from T+1.
  - data_oe rises at T+1+INHIBIT_CYCLES.
  - clk_oe falls at T+1+INHIBIT_CYCLES+REQ_CYCLES.
- Bit update latency: data_oe changes 2 (sync) + FILTER_LEN + 1 clk cycles after the raw ps2_clk falls. This is well inside the ~30 µs low phase.
- done/error: asserted for exactly one cycle, coincident with busy dropping to 0 and tx_ready rising to 1.
- Back-to-back: a new accept is possible the cycle after done/error.

## Test plan
Bench settings: INHIBIT_CYCLES=20, REQ_CYCLES=5, FILTER_LEN=2, TIMEOUT_CYCLES=2000. The bench device model generates a 200-cycle PS/2 clock and samples data on rising edges.

- Send 0xED with a device that ACKs → bits captured 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1; exactly one done pulse; error stays 0; clk_oe high for exactly 20 cycles before data_oe rises.
- Send 0x07 with ACK → parity 0; done pulse; busy low afterwards; tx_ready = 1.
- Send 0xFF with the device holding data high on the 11th edge (NACK) → one error pulse; no done; both oe = 0 next cycle.
- Send 0xF3 with a device that never clocks → error exactly 2000 cycles after clk_oe is released; state back to IDLE.
- Assert rst after the 4th falling edge of a 0xED frame → both oe = 0 and busy = 0 next cycle; a following 0xF4 transfer completes cleanly with done.
- Hold tx_valid high with 0xED, then change to 0xF4 mid-frame → only 0xED is sent; 0xF4 is accepted the cycle after done; glitches of 1 cycle on ps2_clk_in produce no extra bit shifts.
